md_hazard_ctrl: RTL and testbench

- Pipeline stall and multiply/divide scheduling controller for the five-stage CPU.
- Drives `halt` into the D/E pipeline register. While `halt` is high, the F/D stages hold and a bubble enters E.
- Owns the busy counter of the shared mult/div unit (HI/LO). Resolves the D-stage register hazards from each instruction's Tuse and Tnew.
- Honours exception/interrupt `req`: a flush has priority over any stall.

---
 rtl/md_hazard_if.sv | 39 +++
 rtl/md_hazard_ctrl.sv | 45 ++++
 tb/tb_md_hazard_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/md_hazard_if.sv
// md_hazard_if: bus between the pipeline and the hazard/mult-div controller
//   req                  exception/interrupt flush request
//   e_md_start/e_md_div  E-stage mult/div start and div select
//   d_md_use             D-stage instruction touches the mult/div unit or HI/LO
//   d_rs/d_rt            D-stage source indices
//   d_rs_tuse/d_rt_tuse  source Tuse, 3 = not read
//   e_wa/e_tnew          E-stage destination and Tnew
//   m_wa/m_tnew          M-stage destination and Tnew
//   halt                 stall F/D, bubble D/E
//   md_busy/md_count     mult/div unit occupancy
//   md_done              one-cycle completion pulse
interface md_hazard_if;
    logic       req;
    logic       e_md_start;
    logic       e_md_div;
    logic       d_md_use;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_rs_tuse;
    logic [1:0] d_rt_tuse;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       halt;
    logic       md_busy;
    logic [3:0] md_count;
    logic       md_done;
    modport master (
        output req, e_md_start, e_md_div, d_md_use, d_rs, d_rt, d_rs_tuse, d_rt_tuse,
               e_wa, e_tnew, m_wa, m_tnew,
        input  halt, md_busy, md_count, md_done
    );
    modport slave (
        input  req, e_md_start, e_md_div, d_md_use, d_rs, d_rt, d_rs_tuse, d_rt_tuse,
               e_wa, e_tnew, m_wa, m_tnew,
        output halt, md_busy, md_count, md_done
    );
endinterface

// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: D-stage stall generation and shared mult/div busy counter
//   clk    clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    md_hazard_if.slave: hazard inputs in, halt/md_busy/md_count/md_done out
module md_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    md_hazard_if.slave bus
);
    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);
    logic [3:0] count;
    logic       done;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;
    // A running operation always completes; req only blocks a new start.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            done  <= count == 4'd1;
            count <= count != 4'd0 ? count - 4'd1 :
                     (bus.e_md_start & ~bus.req) ? (bus.e_md_div ? DIV_LD : MULT_LD) : count;
        end
    end
    // Tuse of 3 can never be exceeded by a 2-bit Tnew, so unread operands never stall.
    always_comb begin
        stall_rs = (bus.d_rs != 5'd0) &
                   ((bus.d_rs == bus.e_wa & bus.e_tnew > bus.d_rs_tuse) |
                    (bus.d_rs == bus.m_wa & bus.m_tnew > bus.d_rs_tuse));
        stall_rt = (bus.d_rt != 5'd0) &
                   ((bus.d_rt == bus.e_wa & bus.e_tnew > bus.d_rt_tuse) |
                    (bus.d_rt == bus.m_wa & bus.m_tnew > bus.d_rt_tuse));
        stall_md = bus.d_md_use & ((count != 4'd0) | bus.e_md_start);
    end
    assign bus.halt     = ~reset & ~bus.req & (stall_rs | stall_rt | stall_md);
    assign bus.md_busy  = count != 4'd0;
    assign bus.md_count = count;
    assign bus.md_done  = done;
endmodule

// File: tb/tb_md_hazard_ctrl.sv
// tb_md_hazard_ctrl: directed plus random checks against a timeline model of the controller
module tb_md_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int busy_until = 0;
    int done_at = -1;
    md_hazard_if bus ();
    md_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit src_stall(input int s, input int tuse);
        return s != 0 && ((s == int'(bus.e_wa) && int'(bus.e_tnew) > tuse) ||
                          (s == int'(bus.m_wa) && int'(bus.m_tnew) > tuse));
    endfunction

    function automatic int remaining();
        return busy_until > cyc ? busy_until - cyc : 0;
    endfunction

    task automatic clear_inputs();
        bus.req = 0; bus.e_md_start = 0; bus.e_md_div = 0; bus.d_md_use = 0;
        bus.d_rs = 0; bus.d_rt = 0; bus.d_rs_tuse = 3; bus.d_rt_tuse = 3;
        bus.e_wa = 0; bus.e_tnew = 0; bus.m_wa = 0; bus.m_tnew = 0;
    endtask

    // One cycle: check combinational halt, advance the timeline at the edge, check registered outputs.
    task automatic tick();
        int rem;
        bit exp_halt;
        #2;
        rem = remaining();
        exp_halt = !reset && !bus.req &&
                   (src_stall(int'(bus.d_rs), int'(bus.d_rs_tuse)) ||
                    src_stall(int'(bus.d_rt), int'(bus.d_rt_tuse)) ||
                    (bus.d_md_use && (rem != 0 || bus.e_md_start)));
        check("halt", 32'(bus.halt), 32'(exp_halt));
        @(posedge clk);
        cyc++;
        if (reset) begin
            busy_until = cyc;
            done_at = -1;
        end else if (rem == 0 && bus.e_md_start && !bus.req) begin
            busy_until = cyc + (bus.e_md_div ? 10 : 5);
            done_at = busy_until;
        end
        #1;
        check("md_count", 32'(bus.md_count), 32'(remaining()));
        check("md_busy", 32'(bus.md_busy), 32'(remaining() != 0));
        check("md_done", 32'(bus.md_done), 32'(cyc == done_at));
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        tick();
        check("reset_count", 32'(bus.md_count), 0);
        check("reset_halt", 32'(bus.halt), 0);
        // mult: 5,4,3,2,1,0 then done
        bus.e_md_start = 1;
        tick();
        check("mult_load", 32'(bus.md_count), 5);
        bus.e_md_start = 0;
        repeat (6) tick();
        // div with d_md_use held across the whole operation
        bus.e_md_start = 1; bus.e_md_div = 1; bus.d_md_use = 1;
        tick();
        check("div_load", 32'(bus.md_count), 10);
        bus.e_md_start = 0;
        repeat (11) tick();
        check("div_halt_released", 32'(bus.halt), 0);
        clear_inputs();
        // register hazard against E
        bus.d_rs = 8; bus.d_rs_tuse = 0; bus.e_wa = 8; bus.e_tnew = 2;
        tick();
        bus.e_tnew = 0;
        tick();
        bus.d_rs = 0; bus.e_wa = 0; bus.e_tnew = 2;
        tick();
        bus.d_rt = 9; bus.d_rt_tuse = 1; bus.m_wa = 9; bus.m_tnew = 2;
        tick();
        bus.d_rt_tuse = 3; bus.m_tnew = 3;
        tick();
        clear_inputs();
        // start with req suppressed
        bus.e_md_start = 1; bus.req = 1; bus.d_md_use = 1;
        tick();
        check("req_suppress", 32'(bus.md_count), 0);
        clear_inputs();
        // req mid-operation does not abort
        bus.e_md_start = 1; bus.e_md_div = 1;
        tick();
        clear_inputs();
        repeat (3) tick();
        check("count7", 32'(bus.md_count), 7);
        bus.req = 1;
        tick();
        bus.req = 0;
        repeat (8) tick();
        // reset at count 3 kills the operation and its done pulse
        bus.e_md_start = 1;
        tick();
        bus.e_md_start = 0;
        repeat (2) tick();
        check("count3", 32'(bus.md_count), 3);
        reset = 1;
        tick();
        reset = 0;
        check("reset_mid", 32'(bus.md_count), 0);
        repeat (5) tick();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset          = $urandom_range(0, 59) == 0;
            bus.req        = $urandom_range(0, 9) == 0;
            bus.e_md_start = $urandom_range(0, 3) == 0;
            bus.e_md_div   = 1'($urandom);
            bus.d_md_use   = $urandom_range(0, 2) == 0;
            bus.d_rs       = 5'($urandom_range(0, 3));
            bus.d_rt       = 5'($urandom_range(0, 3));
            bus.e_wa       = 5'($urandom_range(0, 3));
            bus.m_wa       = 5'($urandom_range(0, 3));
            bus.d_rs_tuse  = 2'($urandom);
            bus.d_rt_tuse  = 2'($urandom);
            bus.e_tnew     = 2'($urandom);
            bus.m_tnew     = 2'($urandom);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
